// File: rtl/add_sub_seq_pkg.sv
// Shared types and constants for the push-button add/subtract sequencer.
// The state encoding doubles as the externally visible phase value.
package add_sub_seq_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    // Bit-counter width; N is at least 2 so $clog2 never collapses to 0.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Synchronizes the asynchronous active-low key and emits one pulse per press.
// Holding the key or releasing it produces no further pulses.
module key_press_detect (
    input  logic CLK,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic s1;
    logic s2;
    logic s3;

    // Two synchronizer stages plus one history stage; all idle at "released".
    always_ff @(posedge CLK) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign press = s3 & ~s2;

endmodule

// File: rtl/add_sub_sequencer.sv
// Press-driven controller for a bit-serial N-bit add/subtract datapath.
// Chain mode feeds each result back as the next operand A.
module add_sub_sequencer
    import add_sub_seq_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] SW,
    input  logic         key_n,
    input  logic         op_sub,
    input  logic         chain,
    output logic [N-1:0] a_q,
    output logic [N-1:0] b_q,
    output logic [N-1:0] sum_q,
    output logic         cout,
    output logic         busy,
    output logic         done,
    output logic [1:0]   phase
);

    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        state_nx;
    logic          press;
    logic [CW-1:0] cnt;
    logic [N-1:0]  bw;
    logic [N-1:0]  work;
    logic          c;
    logic          last_bit;
    logic          s_bit;
    logic          c_nx;

    key_press_detect u_key (
        .CLK   (CLK),
        .reset (reset),
        .key_n (key_n),
        .press (press)
    );

    assign last_bit = (cnt == CW'(N - 1));
    assign s_bit    = a_q[cnt] ^ bw[cnt] ^ c;
    assign c_nx     = (a_q[cnt] & bw[cnt]) | (a_q[cnt] & c) | (bw[cnt] & c);

    // State register.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        phase    = state;
        unique case (state)
            WAIT_A: if (press) state_nx = WAIT_B;
            WAIT_B: if (press) state_nx = EXEC;
            EXEC: begin
                busy = 1'b1;
                if (last_bit) state_nx = SHOW;
            end
            SHOW: begin
                if (press) state_nx = chain ? WAIT_B : WAIT_A;
            end
            default: state_nx = WAIT_A;
        endcase
    end

    // Operand capture, serial adder slice and result commit.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            bw    <= '0;
            work  <= '0;
            c     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                WAIT_A: begin
                    if (press) a_q <= SW;
                end
                WAIT_B: begin
                    if (press) begin
                        b_q <= SW;
                        bw  <= op_sub ? ~SW : SW;
                        c   <= op_sub;
                        cnt <= '0;
                    end
                end
                EXEC: begin
                    work <= {s_bit, work[N-1:1]};
                    c    <= c_nx;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_q <= {s_bit, work[N-1:1]};
                        cout  <= c_nx;
                        done  <= 1'b1;
                    end
                end
                SHOW: begin
                    if (press && chain) a_q <= sum_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Scoreboard bench for add_sub_sequencer: directed cases plus random ops.
// A negedge monitor checks every committed result against queued expectations.
module tb_add_sub_sequencer;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] SW = '0;
    logic         key_n = 1'b1;
    logic         op_sub = 1'b0;
    logic         chain = 1'b0;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] sum_q;
    logic         cout;
    logic         busy;
    logic         done;
    logic [1:0]   phase;

    add_sub_sequencer #(.N(N)) dut (
        .CLK    (CLK),
        .reset  (reset),
        .SW     (SW),
        .key_n  (key_n),
        .op_sub (op_sub),
        .chain  (chain),
        .a_q    (a_q),
        .b_q    (b_q),
        .sum_q  (sum_q),
        .cout   (cout),
        .busy   (busy),
        .done   (done),
        .phase  (phase)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         busy_run = 0;
    logic [7:0] last_sum = '0;
    logic       last_cout = 1'b0;
    logic [7:0] model_a = '0;
    logic [7:0] model_sum = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: plain modular add/subtract on integers.
    function automatic exp_t ref_op(input logic [7:0] a, input logic [7:0] b,
                                    input logic op);
        exp_t e;
        int   t;
        e.a = a;
        e.b = b;
        if (op) begin
            t      = int'(a) - int'(b);
            e.cout = (a >= b);
        end else begin
            t      = int'(a) + int'(b);
            e.cout = (t > 255);
        end
        e.sum = 8'(t & 255);
        return e;
    endfunction

    // Monitor: result hold during EXEC, busy length, commit contents.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (!reset) begin
            last_sum  = '0;
            last_cout = 1'b0;
            busy_run  = 0;
        end else if (busy) begin
            busy_run++;
            chk("hold_sum", 32'(sum_q), 32'(last_sum));
            chk("hold_cout", 32'(cout), 32'(last_cout));
        end else begin
            if (done) begin
                done_cnt++;
                chk("busy_len", busy_run, N);
                chk("phase_at_done", 32'(phase), 3);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sum_q", 32'(sum_q), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("a_q_at_done", 32'(a_q), 32'(e.a));
                    chk("b_q_at_done", 32'(b_q), 32'(e.b));
                end
                last_sum  = sum_q;
                last_cout = cout;
            end
            busy_run = 0;
        end
    end

    task automatic wait_phase(input logic [1:0] p, input int bound,
                              input string name);
        int i = 0;
        while (i < bound && phase !== p) begin
            @(negedge CLK);
            i++;
        end
        chk(name, 32'(phase), 32'(p));
    endtask

    task automatic press_a(input logic [7:0] a);
        SW    = a;
        key_n = 1'b0;
        @(negedge CLK);
        wait_phase(2'd1, 8, "press_a_phase");
        SW    = 8'($urandom);
        key_n = 1'b1;
        repeat (3) @(negedge CLK);
        model_a = a;
        chk("a_q_capture", 32'(a_q), 32'(a));
    endtask

    task automatic press_b(input logic [7:0] b, input logic op);
        exp_t e;
        e = ref_op(model_a, b, op);
        sb.push_back(e);
        model_sum = e.sum;
        SW     = b;
        op_sub = op;
        key_n  = 1'b0;
        @(negedge CLK);
        wait_phase(2'd2, 8, "press_b_phase");
        SW     = 8'($urandom);
        op_sub = 1'($urandom);
        key_n  = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_show();
        wait_phase(2'd3, 16, "exec_to_show");
        chk("sum_after_show", 32'(sum_q), 32'(model_sum));
    endtask

    task automatic show_press(input logic ch);
        chain = ch;
        key_n = 1'b0;
        @(negedge CLK);
        wait_phase(ch ? 2'd1 : 2'd0, 8, "show_press_phase");
        chain = 1'($urandom);
        key_n = 1'b1;
        repeat (3) @(negedge CLK);
        if (ch) model_a = model_sum;
        chk("a_q_after_show", 32'(a_q), 32'(model_a));
        chk("sum_q_after_show", 32'(sum_q), 32'(model_sum));
    endtask

    task automatic run_op(input logic new_a, input logic [7:0] a,
                          input logic [7:0] b, input logic op,
                          input logic ch);
        if (new_a) press_a(a);
        press_b(b, op);
        wait_show();
        show_press(ch);
    endtask

    initial begin
        int   d0;
        logic chained;

        // Reset with the key bouncing.
        repeat (3) begin
            @(negedge CLK);
            key_n = ~key_n;
        end
        key_n = 1'b1;
        chk("rst_a_q", 32'(a_q), 0);
        chk("rst_b_q", 32'(b_q), 0);
        chk("rst_sum_q", 32'(sum_q), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_phase", 32'(phase), 0);
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_no_done", done_cnt, 0);

        // Directed arithmetic cases.
        run_op(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0);
        run_op(1'b1, 8'hF0, 8'h20, 1'b0, 1'b0);
        run_op(1'b1, 8'h05, 8'h07, 1'b1, 1'b0);
        run_op(1'b1, 8'h42, 8'h42, 1'b1, 1'b0);
        chk("sub_equal_sum", 32'(sum_q), 0);
        chk("sub_equal_cout", 32'(cout), 1);

        // Chain: 1+1 = 2, chained +3 = 5, then leave chain.
        run_op(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
        chk("chain_a_q", 32'(a_q), 32'h02);
        chk("chain_phase", 32'(phase), 1);
        run_op(1'b0, 8'h00, 8'h03, 1'b0, 1'b0);
        chk("chain_sum", 32'(sum_q), 32'h05);
        chk("chain_a_held", 32'(a_q), 32'h02);

        // A press during EXEC is dropped, not queued.
        press_a(8'h11);
        d0 = done_cnt;
        press_b(8'h22, 1'b0);
        key_n = 1'b0;
        repeat (2) @(negedge CLK);
        key_n = 1'b1;
        wait_show();
        repeat (6) @(negedge CLK);
        chk("exec_press_phase", 32'(phase), 3);
        chk("exec_press_sum", 32'(sum_q), 32'h33);
        chk("exec_press_dones", done_cnt - d0, 1);
        show_press(1'b0);

        // Key held for 100 cycles advances exactly one state.
        SW    = 8'h10;
        key_n = 1'b0;
        repeat (100) @(negedge CLK);
        chk("held_key_phase", 32'(phase), 1);
        chk("held_key_a_q", 32'(a_q), 32'h10);
        key_n = 1'b1;
        repeat (3) @(negedge CLK);
        chk("held_release_phase", 32'(phase), 1);
        model_a = 8'h10;
        press_b(8'h20, 1'b1);
        wait_show();
        show_press(1'b0);

        // Reset during EXEC aborts without a commit.
        press_a(8'h77);
        d0 = done_cnt;
        sb.push_back(ref_op(8'h77, 8'h11, 1'b0));
        SW    = 8'h11;
        op_sub = 1'b0;
        key_n = 1'b0;
        @(negedge CLK);
        wait_phase(2'd2, 8, "abort_exec_phase");
        key_n = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        sb.delete();
        chk("abort_phase", 32'(phase), 0);
        chk("abort_sum", 32'(sum_q), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_a_q", 32'(a_q), 0);
        reset = 1'b1;
        model_a   = '0;
        model_sum = '0;
        repeat (12) @(negedge CLK);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle_phase", 32'(phase), 0);

        // Random operations with random chaining.
        chained = 1'b0;
        repeat (25) begin
            logic ch;
            ch = 1'($urandom);
            run_op(!chained, 8'($urandom), 8'($urandom),
                   1'($urandom), ch);
            chained = ch;
        end

        repeat (4) @(negedge CLK);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
